// File: rtl/rc4_stream_encrypt_if.sv
// Plaintext-in / ciphertext-out byte streams of the RC4 encryptor.
// master = upstream feeder / downstream sink, slave = the encryptor.
interface rc4_stream_encrypt_if;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_ready;
  logic [7:0] ct_data;
  logic       ct_valid;
  logic       ct_ready;

  modport master (
    output pt_data, pt_valid, ct_ready,
    input  pt_ready, ct_data, ct_valid
  );

  modport slave (
    input  pt_data, pt_valid, ct_ready,
    output pt_ready, ct_data, ct_valid
  );
endinterface

// File: rtl/rc4_stream_encrypt.sv
// Streaming RC4 encryptor: S-box fill + KSA on start, then one ciphertext
// byte per accepted plaintext byte. S lives in a 256x8 single-port RAM with
// a two-cycle read (registered address, registered q), so every read in the
// FSM is followed by one wait state before the data is consumed.
module rc4_stream_encrypt #(
  parameter int KEY_LENGTH  = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [23:0]            secret_key,
  rc4_stream_encrypt_if.slave    bus,
  output logic                   init_done,
  output logic [COUNT_WIDTH-1:0] byte_count
);

  localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  typedef enum logic [4:0] {
    IDLE,
    FILL,
    K_RI,    // KSA: issue read S[i]
    K_RI1,
    K_RI2,   // S[i] on q: update j, issue read S[j]
    K_RJ1,
    K_RJ2,   // S[j] on q: write S[i] = old S[j]
    K_WJ,    // write S[j] = old S[i], advance i
    WAIT_PT,
    P_RI,    // PRGA: i+1, issue read S[i]
    P_RI1,
    P_RI2,   // S[i] on q: update j, issue read S[j]
    P_RJ1,
    P_RJ2,   // S[j] on q: write S[i] = old S[j]
    P_WJ,    // write S[j] = old S[i]
    P_RK,    // issue read S[S[i]+S[j]]
    P_RK1,
    P_RK2,   // keystream byte on q
    OUT
  } state_t;

  // One S-memory access per cycle: a write when we=1, otherwise a read.
  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } s_req_t;

  state_t state, state_nxt;

  logic [23:0]       key_r;
  logic [7:0]        key_bytes [KEY_LENGTH];
  logic [KIDX_W-1:0] kidx;
  logic [7:0]        i, j, si, sj;
  logic [7:0]        pt_r, ct_r;
  logic              pt_ready_r, ct_valid_r;

  s_req_t            mem_req;
  logic [7:0]        s_mem [256];
  logic [7:0]        addr_r;
  logic [7:0]        q;

  logic [7:0]        j_ksa, j_prga;
  logic              rekey;

  // Key byte n is taken MSB-first from the latched key.
  always_comb begin
    for (int n = 0; n < KEY_LENGTH; n++) key_bytes[n] = key_r[23-8*n -: 8];
  end

  assign j_ksa  = j + q + key_bytes[kidx];
  assign j_prga = j + q;

  // start is honoured only when idle or waiting for plaintext.
  assign rekey = start && ((state == IDLE) || (state == WAIT_PT));

  assign bus.pt_ready = pt_ready_r;
  assign bus.ct_valid = ct_valid_r;
  assign bus.ct_data  = ct_r;

  // S memory: write at the presented address, read through a registered
  // address and registered output (two-cycle read latency, no bypass).
  always_ff @(posedge CLOCK_50) begin
    if (mem_req.we) s_mem[mem_req.addr] <= mem_req.wdata;
    addr_r <= mem_req.addr;
    q      <= s_mem[addr_r];
  end

  // State register plus the registered stream handshake flags.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state      <= IDLE;
      pt_ready_r <= 1'b0;
      ct_valid_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      pt_ready_r <= (state_nxt == WAIT_PT);
      ct_valid_r <= (state_nxt == OUT);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (i == 8'hFF) state_nxt = K_RI;
      K_RI:    state_nxt = K_RI1;
      K_RI1:   state_nxt = K_RI2;
      K_RI2:   state_nxt = K_RJ1;
      K_RJ1:   state_nxt = K_RJ2;
      K_RJ2:   state_nxt = K_WJ;
      K_WJ:    state_nxt = (i == 8'hFF) ? WAIT_PT : K_RI;
      WAIT_PT: begin
        if (start)                        state_nxt = FILL;
        else if (bus.pt_valid && pt_ready_r) state_nxt = P_RI;
      end
      P_RI:    state_nxt = P_RI1;
      P_RI1:   state_nxt = P_RI2;
      P_RI2:   state_nxt = P_RJ1;
      P_RJ1:   state_nxt = P_RJ2;
      P_RJ2:   state_nxt = P_WJ;
      P_WJ:    state_nxt = P_RK;
      P_RK:    state_nxt = P_RK1;
      P_RK1:   state_nxt = P_RK2;
      P_RK2:   state_nxt = OUT;
      OUT:     if (bus.ct_ready && ct_valid_r) state_nxt = WAIT_PT;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request decode: which S location is read or written this cycle.
  always_comb begin
    mem_req = '0;
    case (state)
      FILL:  begin mem_req.we = 1'b1; mem_req.addr = i; mem_req.wdata = i; end
      K_RI:  mem_req.addr = i;
      K_RI2: mem_req.addr = j_ksa;
      K_RJ2: begin mem_req.we = 1'b1; mem_req.addr = i; mem_req.wdata = q;  end
      K_WJ:  begin mem_req.we = 1'b1; mem_req.addr = j; mem_req.wdata = si; end
      P_RI:  mem_req.addr = i + 8'd1;
      P_RI2: mem_req.addr = j_prga;
      P_RJ2: begin mem_req.we = 1'b1; mem_req.addr = i; mem_req.wdata = q;  end
      P_WJ:  begin mem_req.we = 1'b1; mem_req.addr = j; mem_req.wdata = si; end
      // Post-swap S[i]+S[j] equals pre-swap sj+si, so no re-read is needed.
      P_RK:  mem_req.addr = si + sj;
      default: mem_req = '0;
    endcase
  end

  // Datapath: indices, swap operands, key/plaintext latches, outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      key_r      <= '0;
      kidx       <= '0;
      i          <= '0;
      j          <= '0;
      si         <= '0;
      sj         <= '0;
      pt_r       <= '0;
      ct_r       <= '0;
      init_done  <= 1'b0;
      byte_count <= '0;
    end else if (rekey) begin
      key_r      <= secret_key;
      kidx       <= '0;
      i          <= '0;
      j          <= '0;
      init_done  <= 1'b0;
      byte_count <= '0;
    end else begin
      case (state)
        FILL: begin
          i    <= i + 8'd1;
          j    <= '0;
          kidx <= '0;
        end
        K_RI2: begin
          si <= q;
          j  <= j_ksa;
        end
        K_WJ: begin
          i    <= i + 8'd1;
          kidx <= (kidx == KIDX_W'(KEY_LENGTH-1)) ? '0 : kidx + 1'b1;
          if (i == 8'hFF) begin
            j         <= '0;
            init_done <= 1'b1;
          end
        end
        WAIT_PT: if (bus.pt_valid && pt_ready_r) pt_r <= bus.pt_data;
        P_RI:  i  <= i + 8'd1;
        P_RI2: begin
          si <= q;
          j  <= j_prga;
        end
        P_RJ2: sj   <= q;
        P_RK2: ct_r <= pt_r ^ q;
        OUT:   if (bus.ct_ready && ct_valid_r) byte_count <= byte_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_stream_encrypt.sv
// Directed bench for rc4_stream_encrypt: known-answer, backpressure, re-key,
// mid-operation reset, loopback and ignored-input cases, scored through a
// queue of expected ciphertext bytes.
module tb_rc4_stream_encrypt;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] secret_key;
  logic        init_done;
  logic [15:0] byte_count;

  rc4_stream_encrypt_if bus_if();

  rc4_stream_encrypt #(.KEY_LENGTH(3), .COUNT_WIDTH(16)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .start      (start),
    .secret_key (secret_key),
    .bus        (bus_if),
    .init_done  (init_done),
    .byte_count (byte_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];

  logic [7:0] kat_pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] kat_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  // Reference RC4 used for the loopback stream.
  logic [7:0] ms [256];
  logic [7:0] mi, mj;

  task automatic model_init(input logic [23:0] k);
    logic [7:0] t;
    for (int n = 0; n < 256; n++) ms[n] = 8'(n);
    mj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      mj = mj + ms[n] + k[23-8*(n%3) -: 8];
      t = ms[n]; ms[n] = ms[mj]; ms[mj] = t;
    end
    mi = 8'd0;
    mj = 8'd0;
  endtask

  task automatic model_ks(output logic [7:0] ks);
    logic [7:0] t;
    mi = mi + 8'd1;
    mj = mj + ms[mi];
    t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
    t = ms[mi] + ms[mj];
    ks = ms[t];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_start(input logic [23:0] k);
    start = 1'b1;
    secret_key = k;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 5000) begin tick(1); n++; end
    check("init_done_rise", {31'd0, init_done}, 32'd1);
  endtask

  task automatic send_pt(input logic [7:0] b);
    int n = 0;
    while (!bus_if.pt_ready && n < 100) begin tick(1); n++; end
    if (!bus_if.pt_ready) check("pt_ready_wait", {31'd0, bus_if.pt_ready}, 32'd1);
    bus_if.pt_valid = 1'b1;
    bus_if.pt_data  = b;
    tick(1);
    bus_if.pt_valid = 1'b0;
  endtask

  task automatic wait_ct();
    int n = 0;
    while (!bus_if.ct_valid && n < 100) begin tick(1); n++; end
    if (!bus_if.ct_valid) check("ct_valid_wait", {31'd0, bus_if.ct_valid}, 32'd1);
  endtask

  // Pop the oldest expected byte and compare it to the byte being delivered.
  task automatic recv_ct(input string tag, output logic [7:0] got);
    logic [7:0] exp;
    wait_ct();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    got = bus_if.ct_data;
    check(tag, {24'd0, got}, {24'd0, exp});
    tick(1);
  endtask

  task automatic enc(input logic [7:0] pt, input logic [7:0] exp, input string tag,
                     output logic [7:0] got);
    exp_q.push_back(exp);
    send_pt(pt);
    recv_ct(tag, got);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pt_ready"},   {31'd0, bus_if.pt_ready}, 32'd0);
    check({tag, "_ct_valid"},   {31'd0, bus_if.ct_valid}, 32'd0);
    check({tag, "_ct_data"},    {24'd0, bus_if.ct_data},  32'd0);
    check({tag, "_init_done"},  {31'd0, init_done},       32'd0);
    check({tag, "_byte_count"}, {16'd0, byte_count},      32'd0);
  endtask

  task automatic run_kat(input string tag);
    logic [7:0] got;
    for (int k = 0; k < 9; k++) enc(kat_pt[k], kat_ct[k], $sformatf("%s_ct%0d", tag, k), got);
    check({tag, "_count"}, {16'd0, byte_count}, 32'd9);
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] lb_pt [32];
    logic [7:0] lb_ct [32];
    logic [7:0] ks;
    logic       hold_ok;

    reset_n = 1'b0;
    start = 1'b0;
    secret_key = 24'h0;
    bus_if.pt_valid = 1'b1;
    bus_if.pt_data  = 8'hA5;
    bus_if.ct_ready = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Plaintext offered before any start is never taken.
    tick(10);
    check("prestart_pt_ready", {31'd0, bus_if.pt_ready}, 32'd0);
    check("prestart_ct_valid", {31'd0, bus_if.ct_valid}, 32'd0);
    bus_if.pt_valid = 1'b0;

    // Key "Key", with a stray start carrying a different key during FILL.
    do_start(24'h4B6579);
    tick(20);
    do_start(24'h000000);
    wait_init();
    for (int k = 0; k < 4; k++) enc(kat_pt[k], kat_ct[k], $sformatf("kat_ct%0d", k), got);
    check("kat_count4", {16'd0, byte_count}, 32'd4);

    // Re-key in WAIT_PT with a byte offered at the same time.
    bus_if.pt_valid = 1'b1;
    bus_if.pt_data  = kat_pt[4];
    do_start(24'h4B6579);
    bus_if.pt_valid = 1'b0;
    check("rekey_init_done", {31'd0, init_done}, 32'd0);
    check("rekey_count", {16'd0, byte_count}, 32'd0);
    check("rekey_pt_ready", {31'd0, bus_if.pt_ready}, 32'd0);
    tick(15);
    check("rekey_no_ct", {31'd0, bus_if.ct_valid}, 32'd0);
    wait_init();

    // Fresh stream with 20 cycles of backpressure on the second byte.
    enc(kat_pt[0], kat_ct[0], "bp_ct0", got);
    bus_if.ct_ready = 1'b0;
    exp_q.push_back(kat_ct[1]);
    send_pt(kat_pt[1]);
    wait_ct();
    hold_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!(bus_if.ct_valid === 1'b1 && bus_if.ct_data === 8'hF3 && bus_if.pt_ready === 1'b0))
        hold_ok = 1'b0;
      tick(1);
    end
    check("bp_hold_stable", {31'd0, hold_ok}, 32'd1);
    bus_if.ct_ready = 1'b1;
    recv_ct("bp_ct1", got);
    for (int k = 2; k < 9; k++) enc(kat_pt[k], kat_ct[k], $sformatf("bp_ct%0d", k), got);
    check("bp_count", {16'd0, byte_count}, 32'd9);

    // Reset during KSA.
    do_start(24'h4B6579);
    tick(600);
    reset_n = 1'b0;
    tick(1);
    check_reset_outputs("rst_ksa");
    reset_n = 1'b1;

    // Reset while a ciphertext byte is parked in OUT.
    do_start(24'h4B6579);
    wait_init();
    enc(kat_pt[0], kat_ct[0], "rst_out_ct0", got);
    bus_if.ct_ready = 1'b0;
    send_pt(kat_pt[1]);
    wait_ct();
    check("rst_out_parked", {24'd0, bus_if.ct_data}, {24'd0, kat_ct[1]});
    reset_n = 1'b0;
    tick(1);
    check_reset_outputs("rst_out");
    reset_n = 1'b1;
    bus_if.ct_ready = 1'b1;
    exp_q.delete();

    do_start(24'h4B6579);
    wait_init();
    run_kat("post_rst");

    // Loopback: encrypt random bytes, then decrypt them with the same key.
    model_init(24'h000249);
    do_start(24'h000249);
    wait_init();
    for (int k = 0; k < 32; k++) begin
      lb_pt[k] = 8'($urandom_range(0, 255));
      model_ks(ks);
      enc(lb_pt[k], lb_pt[k] ^ ks, $sformatf("lb_enc%0d", k), lb_ct[k]);
    end
    do_start(24'h000249);
    wait_init();
    for (int k = 0; k < 32; k++) enc(lb_ct[k], lb_pt[k], $sformatf("lb_dec%0d", k), got);
    check("lb_count", {16'd0, byte_count}, 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rc4_stream_encrypt.md
Name: rc4_stream_encrypt

Overview:
- Streaming RC4 encryptor: the sender-side counterpart to the ROM-to-RAM decryptor.
- Takes a 24-bit key and runs S-box initialisation (fill plus KSA).
- Then accepts plaintext bytes on a valid/ready input and emits ciphertext bytes on a valid/ready output.
- Used to produce the encrypted message images, and to loop ciphertext back into the decryptor for self-check.

Parameters:
- KEY_LENGTH, 3, key bytes used cyclically in KSA; key byte n = secret_key[23-8n -: 8].
- COUNT_WIDTH, 16, width of the byte_count output.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset (driven from KEY[3] at top level).
- start  in  1  one-cycle pulse; latches secret_key and (re)initialises S.
- secret_key  in  24  RC4 key; sampled only on an accepted start.
- pt_data  in  8  plaintext byte.
- pt_valid  in  1  plaintext byte present.
- pt_ready  out  1  block can accept a plaintext byte this cycle.
- ct_data  out  8  ciphertext byte.
- ct_valid  out  1  ciphertext byte present.
- ct_ready  in  1  downstream accepts ct_data this cycle.
- init_done  out  1  high once KSA has completed for the current key.
- byte_count  out  COUNT_WIDTH  ciphertext bytes delivered since the last start; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; i=j=0.
  - pt_ready=0, ct_valid=0, ct_data=0, init_done=0, byte_count=0.
  - Internal S contents are don't-care.
  - Takes effect from any state, including mid-KSA and mid-byte.
- S memory:
  - internal 256x8 single-port array, one write or one read per cycle.
  - Read data is valid two cycles after the address is driven (registered address, registered q), matching s_memory timing.
  - No read-during-write bypass is relied upon.
- Arithmetic: all index and keystream arithmetic is 8-bit modulo 256; i and j are 8-bit.
- IDLE:
  - Waits for start. start=1 -> latch key, clear init_done and byte_count, go to FILL.
- FILL:
  - Writes S[n]=n for n=0..255, one per cycle (256 cycles).
  - Then i=j=0, go to KSA.
- KSA (per i=0..255):
  - Read S[i].
  - j = j + S[i] + key[i mod KEY_LENGTH].
  - Read S[j].
  - Write S[i]=old S[j], then S[j]=old S[i]. When i==j the result is an unchanged S[i].
  - After i=255: i=j=0, init_done=1, go to WAIT_PT.
- WAIT_PT:
  - pt_ready=1 (registered, asserted only in this state).
  - Transfer occurs when pt_valid & pt_ready; latch pt_data, drop pt_ready next cycle, go to PRGA.
  - start=1 in this state (with or without pt_valid) takes priority: the byte is not accepted, the block re-keys and goes to FILL.
- PRGA (per byte):
  - i = i+1; read S[i].
  - j = j + S[i]; read S[j].
  - Swap S[i] and S[j].
  - Read S[(S[i]+S[j]) mod 256] using post-swap values; call the result K.
  - ct_data = pt ^ K; go to OUT.
- OUT:
  - ct_valid=1; ct_data held stable until ct_valid & ct_ready.
  - On transfer: ct_valid=0 next cycle, byte_count+1, go to WAIT_PT.
  - start is ignored in OUT and PRGA.
- Throughput: minimum 10 cycles from a pt transfer to ct_valid, with no overlap between bytes. Tests check order and values, not exact latency.
- start in FILL or KSA is ignored; the key stays as latched.
- Byte count wrap: byte_count wraps 0xFFFF -> 0x0000 with no effect on the stream.
- Keystream position persists across idle gaps of any length; only start or reset restarts it.

Test Plan:
1. Known-answer test:
   - Key "Key": secret_key=24'h4B6579; start; wait init_done.
   - Stream "Plaintext" (50 6C 61 69 6E 74 65 78 74) with ct_ready=1.
   - Required: ct = BB F3 16 E8 D9 40 AF 0A D3; byte_count=9.
2. Backpressure:
   - Same key as (1); ct_ready held 0 for 20 cycles on byte 2.
   - Required: ct_valid stays 1 with ct_data=F3 stable; pt_ready=0 throughout; the remaining bytes still match (1).
3. Re-key:
   - After 4 bytes of (1), pulse start in WAIT_PT with pt_valid=1.
   - Required: that byte is not accepted; init_done drops, then rises; byte_count=0; a fresh "Plaintext" yields BB F3 16 ... again.
4. Reset mid-operation:
   - Assert reset_n=0 for 1 cycle during KSA and again during OUT.
   - Required: next cycle all outputs are 0 and state is IDLE; a subsequent start plus (1) passes.
5. Loopback:
   - secret_key=24'h000249; encrypt 32 random bytes, then re-run start with the same key and feed the ciphertext back in.
   - Required: the original 32 bytes are recovered exactly.
6. Idle and ignored inputs:
   - pt_valid=1 before any start: pt_ready stays 0 and ct_valid stays 0.
   - start pulses during FILL are ignored: the KSA result matches (1).
